// File: rtl/hdmi_video_timing.sv
// hdmi_video_timing: 640x480@60 raster generator for the HDMI output path.
// Waits for the pixel PLL lock to be stable for LOCK_WAIT cycles, then runs
// free-running h/v counters and decodes registered sync, DE, coordinates and
// a start-of-frame pulse. Losing lock drops straight back to the idle state.
module hdmi_video_timing #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int LOCK_WAIT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       running,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEGIN = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEGIN = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ON = (HSYNC_POL != 0) ? 1'b1 : 1'b0;
  localparam logic VS_ON = (VSYNC_POL != 0) ? 1'b1 : 1'b0;

  // Lock counter is wide enough to hold LOCK_WAIT-1 for any LOCK_WAIT >= 1.
  localparam int              LCW       = $clog2(LOCK_WAIT) + 1;
  localparam logic [LCW-1:0]  LOCK_LAST = LCW'(LOCK_WAIT - 1);
  localparam logic [LCW-1:0]  LOCK_ONE  = LCW'(1);

  typedef enum logic [0:0] {
    ST_WAIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_r;
  logic             sync_meta_r;
  logic             lk_s_r;
  logic [LCW-1:0]   lock_cnt_r;
  logic [9:0]       h_cnt_r;
  logic [9:0]       v_cnt_r;

  logic             de_s;
  logic             hs_on_s;
  logic             vs_on_s;
  logic             fs_s;
  logic [9:0]       x_s;
  logic [9:0]       y_s;

  // Two-flop synchronizer for the asynchronous PLL lock indicator.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta_r <= 1'b0;
      lk_s_r      <= 1'b0;
    end else begin
      sync_meta_r <= pll_locked;
      lk_s_r      <= sync_meta_r;
    end
  end

  // Lock qualification FSM and raster counters; running mirrors the RUN state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_WAIT;
      running    <= 1'b0;
      lock_cnt_r <= '0;
      h_cnt_r    <= 10'd0;
      v_cnt_r    <= 10'd0;
    end else begin
      case (state_r)
        ST_WAIT: begin
          h_cnt_r <= 10'd0;
          v_cnt_r <= 10'd0;
          if (lk_s_r) begin
            if (lock_cnt_r == LOCK_LAST) begin
              state_r    <= ST_RUN;
              running    <= 1'b1;
              lock_cnt_r <= '0;
            end else begin
              lock_cnt_r <= lock_cnt_r + LOCK_ONE;
            end
          end else begin
            lock_cnt_r <= '0;
          end
        end
        ST_RUN: begin
          if (!lk_s_r) begin
            // Lock lost: abandon the frame immediately, no completion.
            state_r    <= ST_WAIT;
            running    <= 1'b0;
            lock_cnt_r <= '0;
            h_cnt_r    <= 10'd0;
            v_cnt_r    <= 10'd0;
          end else if (h_cnt_r == H_LAST) begin
            h_cnt_r <= 10'd0;
            if (v_cnt_r == V_LAST) begin
              v_cnt_r <= 10'd0;
            end else begin
              v_cnt_r <= v_cnt_r + 10'd1;
            end
          end else begin
            h_cnt_r <= h_cnt_r + 10'd1;
          end
        end
        default: begin
          state_r    <= ST_WAIT;
          running    <= 1'b0;
          lock_cnt_r <= '0;
          h_cnt_r    <= 10'd0;
          v_cnt_r    <= 10'd0;
        end
      endcase
    end
  end

  // Decode the current counter state into next-cycle output values.
  always_comb begin
    de_s    = 1'b0;
    x_s     = 10'd0;
    y_s     = 10'd0;
    hs_on_s = (h_cnt_r >= HS_BEGIN) && (h_cnt_r < HS_END);
    vs_on_s = (v_cnt_r >= VS_BEGIN) && (v_cnt_r < VS_END);
    fs_s    = (h_cnt_r == 10'd0) && (v_cnt_r == 10'd0);
    if ((h_cnt_r < H_ACT) && (v_cnt_r < V_ACT)) begin
      de_s = 1'b1;
      x_s  = h_cnt_r;
      y_s  = v_cnt_r;
    end else begin
      de_s = 1'b0;
      x_s  = 10'd0;
      y_s  = 10'd0;
    end
  end

  // Output register stage: one cycle behind the counters, idle outside RUN.
  always_ff @(posedge clk) begin
    if (rst || (state_r != ST_RUN)) begin
      de          <= 1'b0;
      x           <= 10'd0;
      y           <= 10'd0;
      frame_start <= 1'b0;
      hsync       <= ~HS_ON;
      vsync       <= ~VS_ON;
    end else begin
      de          <= de_s;
      x           <= x_s;
      y           <= y_s;
      frame_start <= fs_s;
      hsync       <= hs_on_s ? HS_ON : ~HS_ON;
      vsync       <= vs_on_s ? VS_ON : ~VS_ON;
    end
  end

endmodule
